zion_skid_buf_clr: RTL and testbench
====================================

Name: zion_skid_buf_clr

Overview:
- Two-entry valid/ready skid buffer with synchronous flush.
- Sits directly upstream of a clear/enable register stage: the registered output data, valid and flush feed that stage's data, enable and clear inputs.
- Breaks the combinational ready path: oRdy is a register output.
- Sustains one transfer per cycle with no bubbles.

Parameters:
- WIDTH, 32, data width in bits.
- INI_DATA, 32'h1, value loaded into both data registers on reset and on flush; truncated/zero-extended to WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-low.
- iClr  in  1  synchronous flush.
- iVld  in  1  upstream data valid.
- oRdy  out  1  ready to upstream; registered.
- iDat  in  WIDTH  upstream data.
- oVld  out  1  valid to downstream; registered.
- iRdy  in  1  downstream ready.
- oDat  out  WIDTH  data to downstream; driven by main register.
- oCnt  out  2  occupancy, 0..2.

Behaviour:
- Handshakes:
  - Input fire: inFire = iVld & oRdy.
  - Output fire: outFire = oVld & iRdy.
  - Both sampled at posedge clk.
- Reset (rst==0 at posedge):
  - state=EMPTY; oVld=0; oRdy=0; oCnt=0; main=skid=INI_DATA.
  - oRdy rises to 1 on the first posedge with rst==1.
- Flush (rst==1, iClr==1):
  - Same register values as reset, except oRdy=1 next cycle.
  - Any same-cycle inFire is dropped. Any same-cycle outFire counts as completed downstream; the buffer does not retain it.
- Priority: reset > flush > normal operation.
- States (2-bit enum): EMPTY (oCnt 0), BUSY (1), FULL (2).
  - oVld = (state != EMPTY).
  - oRdy = (next state != FULL), registered.
- Transitions (iClr==0):
  - EMPTY, inFire -> BUSY, main<=iDat. Otherwise stay.
  - BUSY, inFire & outFire -> BUSY, main<=iDat.
  - BUSY, inFire only -> FULL, skid<=iDat.
  - BUSY, outFire only -> EMPTY; main holds its value.
  - BUSY, neither -> hold.
  - FULL, outFire -> BUSY, main<=skid. inFire is impossible here because oRdy=0.
  - FULL, no outFire -> hold.
- Latency: 1 cycle from inFire to oVld/oDat when EMPTY. Throughput: 1 beat/cycle when iRdy is held high.
- Stability:
  - While oVld & !iRdy, oDat and oVld are held constant.
  - Ordering is strictly FIFO. No loss or duplication except on flush.
- Data registers update only on the cases above. oDat when EMPTY is the last transferred value, or INI_DATA after reset/flush.
- Upstream obligation, not checked in RTL: iDat stable while iVld & !oRdy.
- Bench assertions:
  - oCnt == number of accepted beats minus delivered beats since the last flush.
  - oRdy==0 only when FULL or during reset.

Decomposition:
- Package zion_skid_pkg:
  - typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_e.
  - Occupancy constants CNT_EMPTY/CNT_BUSY/CNT_FULL.
- No sub-module. Main and skid data registers are inline clear/enable registers: clear = ~rst | iClr, enable = their load condition above.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1 -> oVld=0, oDat=32'h1, oCnt=0 during reset; oRdy=1 on the first cycle after release.
- Streaming: iRdy=1, iVld=1, iDat=10,11,12,13 on consecutive cycles -> oDat=10,11,12,13 one cycle later each; oCnt stays 1; oRdy never drops.
- Backpressure: iRdy=0, push 20 then 21 -> oCnt=2, oRdy=0, oDat holds 20. Raise iRdy -> oDat 20 then 21, oCnt 2->1->0, oRdy=1 one cycle after the first outFire.
- Flush while FULL with iVld=1, iDat=99: assert iClr one cycle -> next cycle oVld=0, oCnt=0, oDat=32'h1, oRdy=1; 99 is never output.
- Random: iVld/iRdy random 50% for 1000 cycles, incrementing iDat -> output sequence strictly increments with no gaps; oDat stable under stall.
- Reset mid-operation while FULL (entries 5,6) -> next cycle oVld=0, oDat=32'h1; 5 and 6 never appear afterward.

Source files
------------

// File: rtl/zion_skid_pkg.sv
// Shared types and constants for the two-entry skid buffer with flush.
package zion_skid_pkg;

    // Buffer occupancy state; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_BUSY  = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    // Number of buffered beats held in a given state.
    function automatic logic [1:0] cnt_of(skid_state_e st);
        logic [1:0] cnt;
        cnt = CNT_EMPTY;
        case (st)
            BUSY:    cnt = CNT_BUSY;
            FULL:    cnt = CNT_FULL;
            default: cnt = CNT_EMPTY;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/zion_skid_buf_clr.sv
// Two-entry valid/ready skid buffer with synchronous flush. The ready seen
// upstream is a flop, so no combinational path runs from iRdy to oRdy, yet
// the second (skid) entry lets it stream one beat per cycle without bubbles.
module zion_skid_buf_clr
    import zion_skid_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] INI_DATA = 32'h1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat,
    output logic [1:0]       oCnt
);

    localparam logic [WIDTH-1:0] INI_W = WIDTH'(INI_DATA);

    skid_state_e      state_q, state_d;
    logic             vld_q;
    logic             rdy_q;
    logic [1:0]       cnt_q;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q;
    logic             main_ld;
    logic             skid_ld;
    logic             in_fire;
    logic             out_fire;
    logic             data_clr;

    assign in_fire  = iVld & rdy_q;
    assign out_fire = vld_q & iRdy;
    // Data registers share the clear of the downstream clear/enable stage.
    assign data_clr = ~rst | iClr;

    // Next state and data-register load selection from the two handshakes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = iDat;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_ld = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_ld = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_ld = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // oRdy is low here, so only a drain can happen.
                if (out_fire) begin
                    state_d = BUSY;
                    main_ld = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Control flops: state plus registered valid, ready and occupancy.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b0;
            cnt_q   <= CNT_EMPTY;
        end else if (iClr) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            cnt_q   <= CNT_EMPTY;
        end else begin
            state_q <= state_d;
            vld_q   <= (state_d != EMPTY);
            rdy_q   <= (state_d != FULL);
            cnt_q   <= cnt_of(state_d);
        end
    end

    // Main data register: clear/enable, drives oDat directly.
    always_ff @(posedge clk) begin
        // NOTE: data registers are reset because oDat is observable while
        // EMPTY and must read INI_DATA after reset or flush.
        if (data_clr) begin
            main_q <= INI_W;
        end else if (main_ld) begin
            main_q <= main_d;
        end
    end

    // Skid data register: captures the beat that arrives while main stalls.
    always_ff @(posedge clk) begin
        if (data_clr) begin
            skid_q <= INI_W;
        end else if (skid_ld) begin
            skid_q <= iDat;
        end
    end

    assign oVld = vld_q;
    assign oRdy = rdy_q;
    assign oDat = main_q;
    assign oCnt = cnt_q;

endmodule

// File: tb/tb_zion_skid_buf_clr.sv
// Self-checking bench for zion_skid_buf_clr: directed vector table, a reset
// while full, and a randomized run against a queue-based reference model.
module tb_zion_skid_buf_clr;

    logic        clk;
    logic        rst;
    logic        iClr;
    logic        iVld;
    logic        oRdy;
    logic [31:0] iDat;
    logic        oVld;
    logic        iRdy;
    logic [31:0] oDat;
    logic [1:0]  oCnt;

    int n_cmp = 0;
    int n_err = 0;
    logic prev_rst = 1'b0;

    zion_skid_buf_clr #(.WIDTH(32), .INI_DATA(32'h1)) dut (
        .clk  (clk),
        .rst  (rst),
        .iClr (iClr),
        .iVld (iVld),
        .oRdy (oRdy),
        .iDat (iDat),
        .oVld (oVld),
        .iRdy (iRdy),
        .oDat (oDat),
        .oCnt (oCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then move to 1 time unit past the edge.
    task automatic apply(input logic r, input logic c, input logic v,
                         input logic [31:0] d, input logic rd);
        rst  = r;
        iClr = c;
        iVld = v;
        iDat = d;
        iRdy = rd;
        @(posedge clk);
        #1;
    endtask

    // oRdy may only be low when two beats are held, unless reset was applied.
    always @(posedge clk) prev_rst <= rst;
    always @(negedge clk) begin
        if (prev_rst && !oRdy) check("rdy_low_only_full", {30'd0, oCnt}, 32'd2);
    end

    typedef struct {
        logic        rst;
        logic        clr;
        logic        vld;
        logic [31:0] dat;
        logic        rdy;
        logic        e_vld;
        logic        e_rdy;
        logic [31:0] e_dat;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int q[$];
        logic [31:0] last_out;
        logic [31:0] exp_dat;
        logic [31:0] prev_dat;
        logic        m_rdy;
        logic        prev_stall;
        logic        in_f;
        logic        out_f;
        int          next_send;
        int          next_exp;

        //             rst   clr   vld   dat    rdy | vld   rdy   dat    cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'h1, 2'd0}; // reset
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'h1, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 32'h1, 2'd0}; // release
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'd10, 1'b1, 1'b1, 1'b1, 32'd10, 2'd1}; // stream
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'd11, 1'b1, 1'b1, 1'b1, 32'd11, 2'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'd12, 1'b1, 1'b1, 1'b1, 32'd12, 2'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'd13, 1'b1, 1'b1, 1'b1, 32'd13, 2'd1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'd13, 1'b1, 1'b0, 1'b1, 32'd13, 2'd0}; // drained
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'd20, 1'b0, 1'b1, 1'b1, 32'd20, 2'd1}; // backpressure
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'd21, 1'b0, 1'b1, 1'b0, 32'd20, 2'd2};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'd22, 1'b0, 1'b1, 1'b0, 32'd20, 2'd2}; // not accepted
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'd22, 1'b1, 1'b1, 1'b1, 32'd21, 2'd1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'd22, 1'b1, 1'b0, 1'b1, 32'd21, 2'd0};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 32'd30, 1'b0, 1'b1, 1'b1, 32'd30, 2'd1}; // fill
        vecs[14] = '{1'b1, 1'b0, 1'b1, 32'd31, 1'b0, 1'b1, 1'b0, 32'd30, 2'd2};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 32'd99, 1'b0, 1'b0, 1'b1, 32'h1, 2'd0}; // flush full
        vecs[16] = '{1'b1, 1'b0, 1'b0, 32'd99, 1'b1, 1'b0, 1'b1, 32'h1, 2'd0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 32'd77, 1'b1, 1'b0, 1'b1, 32'h1, 2'd0}; // flush drops in
        vecs[18] = '{1'b1, 1'b0, 1'b0, 32'd77, 1'b1, 1'b0, 1'b1, 32'h1, 2'd0};

        rst  = 1'b0;
        iClr = 1'b0;
        iVld = 1'b0;
        iDat = 32'd0;
        iRdy = 1'b0;
        #2;

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].rst, vecs[i].clr, vecs[i].vld, vecs[i].dat, vecs[i].rdy);
            check($sformatf("vec%0d_vld", i), {31'd0, oVld}, {31'd0, vecs[i].e_vld});
            check($sformatf("vec%0d_rdy", i), {31'd0, oRdy}, {31'd0, vecs[i].e_rdy});
            check($sformatf("vec%0d_dat", i), oDat, vecs[i].e_dat);
            check($sformatf("vec%0d_cnt", i), {30'd0, oCnt}, {30'd0, vecs[i].e_cnt});
        end

        // Reset while holding 5 and 6: both must vanish.
        apply(1'b1, 1'b0, 1'b1, 32'd5, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 32'd6, 1'b0);
        check("midrst_full_cnt", {30'd0, oCnt}, 32'd2);
        check("midrst_full_dat", oDat, 32'd5);
        apply(1'b0, 1'b0, 1'b0, 32'd6, 1'b1);
        check("midrst_vld", {31'd0, oVld}, 32'd0);
        check("midrst_rdy", {31'd0, oRdy}, 32'd0);
        check("midrst_dat", oDat, 32'h1);
        check("midrst_cnt", {30'd0, oCnt}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 32'd6, 1'b1);
            check($sformatf("postrst%0d_rdy", i), {31'd0, oRdy}, 32'd1);
            check($sformatf("postrst%0d_vld", i), {31'd0, oVld}, 32'd0);
            check($sformatf("postrst%0d_dat", i), oDat, 32'h1);
        end

        // Randomized traffic against a FIFO model of the buffer contents.
        last_out   = 32'h1;
        m_rdy      = 1'b1;
        prev_stall = 1'b0;
        prev_dat   = 32'h1;
        next_send  = 1000;
        next_exp   = 1000;
        for (int c = 0; c < 1000; c++) begin
            exp_dat = (q.size() > 0) ? q[0] : last_out;
            check("rnd_vld", {31'd0, oVld}, {31'd0, q.size() > 0});
            check("rnd_rdy", {31'd0, oRdy}, {31'd0, m_rdy});
            check("rnd_cnt", {30'd0, oCnt}, 32'(q.size()));
            check("rnd_dat", oDat, exp_dat);
            if (prev_stall) check("rnd_stall_stable", oDat, prev_dat);

            iVld = 1'($urandom_range(0, 1));
            iRdy = 1'($urandom_range(0, 1));
            iDat = 32'(next_send);
            in_f  = iVld && m_rdy;
            out_f = (q.size() > 0) && iRdy;
            if (out_f) begin
                check("rnd_order", oDat, 32'(next_exp));
                next_exp++;
                last_out = q.pop_front();
            end
            if (in_f) begin
                q.push_back(next_send);
                next_send++;
            end
            m_rdy      = (q.size() < 2);
            prev_stall = oVld && !iRdy;
            prev_dat   = oDat;
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
